// File: rtl/spi_rom_responder.sv
// spi_rom_responder: SPI flash-ROM target for the serial READ (03h) stream.
// Decodes the command and 24-bit address from MOSI and fetches bytes from a
// synchronous ROM read port. Bytes are shifted MSB-first onto MISO, and the
// address auto-increments after each byte.
// All SPI pins are oversampled by clk. Chip select is active-high.
// Optional feature macro: SPI_ROM_FAST_READ_EN
//   defined   -> FAST_READ (0Bh) is accepted, with 8 dummy clocks before data
//   undefined -> 0Bh is unsupported and the responder ignores the transfer
// ROM port timing: rom_data reflects rom_addr one clk after rom_addr changes.
//   The responder therefore captures the prefetch byte two clk after it
//   updates rom_addr.
// dbg_state exposes the FSM state encoding for checkers.
module spi_rom_responder #(
  parameter int ADDR_BITS = 11
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 spi_cs,
  input  logic                 spi_sclk,
  input  logic                 spi_mosi,
  output logic                 spi_miso,
  output logic [ADDR_BITS-1:0] rom_addr,
  input  logic [7:0]           rom_data,
  output logic                 active,
  output logic [2:0]           dbg_state
);

`ifdef SPI_ROM_FAST_READ_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_DUMMY  = 3'd3,
    ST_DATA   = 3'd4,
    ST_IGNORE = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_DATA   = 3'd4,
    ST_IGNORE = 3'd5
  } state_t;
`endif

  localparam logic [ADDR_BITS-1:0] ADDR_ONE = {{(ADDR_BITS-1){1'b0}}, 1'b1};

  state_t state, state_nxt;

  // Synchronizer stages.
  // The third stage holds the level/strobe outputs used by the FSM.
  logic cs_s1, cs_s2, cs_lvl, cs_rise;
  logic sclk_s1, sclk_s2, sclk_d, sclk_rise, sclk_fall;
  logic mosi_s1, mosi_s2, mosi_smp;

  // Protocol datapath
  logic [4:0]           bit_cnt;
  logic [6:0]           cmd_sr;
  logic [ADDR_BITS-1:0] addr_sr;
  logic [6:0]           shift_sr;
  logic [7:0]           prefetch;
  logic [1:0]           fetch_pipe;
  logic [7:0]           cmd_word;
  logic [ADDR_BITS-1:0] addr_word;
`ifdef SPI_ROM_FAST_READ_EN
  logic                 fast_flag;
`endif

  assign cmd_word  = {cmd_sr, mosi_smp};
  assign addr_word = {addr_sr[ADDR_BITS-2:0], mosi_smp};
  assign active    = (state != ST_IDLE);
  assign dbg_state = state;

  // Two-FF synchronizers, then a registered edge detect on the third stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cs_s1     <= 1'b0;
      cs_s2     <= 1'b0;
      cs_lvl    <= 1'b0;
      cs_rise   <= 1'b0;
      sclk_s1   <= 1'b0;
      sclk_s2   <= 1'b0;
      sclk_d    <= 1'b0;
      sclk_rise <= 1'b0;
      sclk_fall <= 1'b0;
      mosi_s1   <= 1'b0;
      mosi_s2   <= 1'b0;
      mosi_smp  <= 1'b0;
    end else begin
      cs_s1     <= spi_cs;
      cs_s2     <= cs_s1;
      cs_lvl    <= cs_s2;
      cs_rise   <= cs_s2 & ~cs_lvl;
      sclk_s1   <= spi_sclk;
      sclk_s2   <= sclk_s1;
      sclk_d    <= sclk_s2;
      sclk_rise <= sclk_s2 & ~sclk_d;
      sclk_fall <= ~sclk_s2 & sclk_d;
      mosi_s1   <= spi_mosi;
      mosi_s2   <= mosi_s1;
      mosi_smp  <= mosi_s2;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. A low chip select overrides everything else.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (cs_rise) state_nxt = ST_CMD;
      end
      ST_CMD: begin
        if (sclk_rise && bit_cnt == 5'd7) begin
          if (cmd_word == 8'h03) begin
            state_nxt = ST_ADDR;
`ifdef SPI_ROM_FAST_READ_EN
          end else if (cmd_word == 8'h0B) begin
            state_nxt = ST_ADDR;
`endif
          end else begin
            state_nxt = ST_IGNORE;
          end
        end
      end
      ST_ADDR: begin
        if (sclk_rise && bit_cnt == 5'd23) begin
`ifdef SPI_ROM_FAST_READ_EN
          state_nxt = fast_flag ? ST_DUMMY : ST_DATA;
`else
          state_nxt = ST_DATA;
`endif
        end
      end
`ifdef SPI_ROM_FAST_READ_EN
      ST_DUMMY: begin
        if (sclk_rise && bit_cnt == 5'd7) state_nxt = ST_DATA;
      end
`endif
      ST_DATA:   state_nxt = ST_DATA;
      ST_IGNORE: state_nxt = ST_IGNORE;
      default:   state_nxt = ST_IDLE;
    endcase
    if (!cs_lvl) state_nxt = ST_IDLE;
  end

  // Datapath:
  //  - shift command and address bits on SCLK rises
  //  - emit data bits on SCLK falls
  //  - run the ROM prefetch
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      spi_miso   <= 1'b0;
      rom_addr   <= '0;
      bit_cnt    <= 5'd0;
      cmd_sr     <= 7'd0;
      addr_sr    <= '0;
      shift_sr   <= 7'd0;
      prefetch   <= 8'd0;
      fetch_pipe <= 2'b00;
`ifdef SPI_ROM_FAST_READ_EN
      fast_flag  <= 1'b0;
`endif
    end else begin
      fetch_pipe <= {fetch_pipe[0], 1'b0};
      if (fetch_pipe[1]) prefetch <= rom_data;

      if (!cs_lvl) begin
        // Deselect discards any partial command or address.
        spi_miso   <= 1'b0;
        bit_cnt    <= 5'd0;
        cmd_sr     <= 7'd0;
        addr_sr    <= '0;
        shift_sr   <= 7'd0;
        fetch_pipe <= 2'b00;
`ifdef SPI_ROM_FAST_READ_EN
        fast_flag  <= 1'b0;
`endif
      end else begin
        case (state)
          ST_IDLE: begin
            spi_miso <= 1'b0;
            bit_cnt  <= 5'd0;
          end
          ST_CMD: begin
            if (sclk_rise) begin
              cmd_sr <= cmd_word[6:0];
              if (bit_cnt == 5'd7) begin
                bit_cnt <= 5'd0;
`ifdef SPI_ROM_FAST_READ_EN
                fast_flag <= (cmd_word == 8'h0B);
`endif
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end
          ST_ADDR: begin
            if (sclk_rise) begin
              addr_sr <= addr_word;
              if (bit_cnt == 5'd23) begin
                bit_cnt    <= 5'd0;
                rom_addr   <= addr_word;
                fetch_pipe <= 2'b01;
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end
`ifdef SPI_ROM_FAST_READ_EN
          ST_DUMMY: begin
            spi_miso <= 1'b0;
            if (sclk_rise) begin
              bit_cnt <= (bit_cnt == 5'd7) ? 5'd0 : bit_cnt + 5'd1;
            end
          end
`endif
          ST_DATA: begin
            if (sclk_fall) begin
              if (bit_cnt == 5'd0) begin
                shift_sr   <= prefetch[6:0];
                spi_miso   <= prefetch[7];
                rom_addr   <= rom_addr + ADDR_ONE;
                fetch_pipe <= 2'b01;
              end else begin
                spi_miso <= shift_sr[6];
                shift_sr <= {shift_sr[5:0], 1'b0};
              end
              bit_cnt <= (bit_cnt == 5'd7) ? 5'd0 : bit_cnt + 5'd1;
            end
          end
          ST_IGNORE: begin
            spi_miso <= 1'b0;
          end
          default: begin
            spi_miso <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_rom_responder.sv
// Bench for spi_rom_responder. The initiator is driven in SPI mode 0.
// The expected MISO and active values at every SCLK rise come from a
// transaction-level model of the READ protocol. ROM[i] = i ^ A5h.
module tb_spi_rom_responder;
  localparam int AB = 11;

`ifdef SPI_ROM_FAST_READ_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          spi_cs = 1'b0;
  logic          spi_sclk = 1'b0;
  logic          spi_mosi = 1'b0;
  logic          spi_miso;
  logic [AB-1:0] rom_addr;
  logic [7:0]    rom_data = 8'd0;
  logic          active;
  logic [2:0]    dbg_state;

  int checks = 0;
  int failures = 0;
  logic [1:0] exp_q[$];
  logic       rx_bits[$];
  logic [7:0] rom_mem [0:(1<<AB)-1];

  spi_rom_responder #(.ADDR_BITS(AB)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .spi_cs    (spi_cs),
    .spi_sclk  (spi_sclk),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .active    (active),
    .dbg_state (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Synchronous ROM read port
  initial begin
    for (int i = 0; i < (1 << AB); i++) rom_mem[i] = 8'(i) ^ 8'hA5;
  end
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: the MISO bit the initiator must see at rise number i (0-based).
  function automatic logic model_bit(input logic [7:0] cmd, input logic [23:0] addr, input int i);
    logic          ok;
    int            hdr;
    int            k;
    logic [AB-1:0] a;
    logic [7:0]    b;
    ok  = (cmd == 8'h03) || (FAST && cmd == 8'h0B);
    hdr = (cmd == 8'h0B) ? 40 : 32;
    if (!ok || i < hdr) return 1'b0;
    k = i - hdr;
    a = addr[AB-1:0] + AB'(k / 8);
    b = a[7:0] ^ 8'hA5;
    return b[7 - (k % 8)];
  endfunction

  function automatic logic [7:0] rx_byte(input int off);
    logic [7:0] b = 8'd0;
    for (int j = 0; j < 8; j++) b = {b[6:0], rx_bits[off + j]};
    return b;
  endfunction

  // Scoreboard: compare at every SCLK rise, which is where the initiator samples.
  always @(posedge spi_sclk) begin
    logic [1:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL sclk_rise_no_expectation t=%0t", $time);
    end else begin
      e = exp_q.pop_front();
      chk("miso_bit", {31'd0, spi_miso}, {31'd0, e[0]});
      chk("active_in_xfer", {31'd0, active}, {31'd0, e[1]});
    end
  end

  // Driver: one CS-framed transfer of nbits SCLK periods with half-period half.
  // If reset_at >= 0, reset_n is pulsed right after that rise.
  task automatic xfer(input logic [7:0] cmd, input logic [23:0] addr, input int nbits,
                      input int half, input int reset_at);
    logic [31:0] hdr_bits;
    hdr_bits = {cmd, addr};
    rx_bits.delete();
    @(negedge clk);
    spi_cs = 1'b1;
    repeat (half) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = (i < 32) ? hdr_bits[31 - i] : 1'($urandom_range(0, 1));
      repeat (half) @(negedge clk);
      exp_q.push_back({1'b1, model_bit(cmd, addr, i)});
      spi_sclk = 1'b1;
      rx_bits.push_back(spi_miso);
      if (i == reset_at) begin
        #3;
        reset_n = 1'b0;
        #1;
        chk("rst_miso", {31'd0, spi_miso}, 32'd0);
        chk("rst_rom_addr", {21'd0, rom_addr}, 32'd0);
        chk("rst_active", {31'd0, active}, 32'd0);
        spi_cs   = 1'b0;
        spi_sclk = 1'b0;
        spi_mosi = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        return;
      end
      repeat (half) @(negedge clk);
      spi_sclk = 1'b0;
    end
    repeat (half) @(negedge clk);
    spi_cs   = 1'b0;
    spi_mosi = 1'b0;
    repeat (6) @(negedge clk);
    chk("idle_miso", {31'd0, spi_miso}, 32'd0);
    chk("idle_active", {31'd0, active}, 32'd0);
  endtask

  // Watchdog
  initial begin
    #5_000_000;
    $display("FAIL watchdog_timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

  // Test sequence
  initial begin
    logic [7:0]  cmd;
    logic [23:0] addr;
    int          nbytes;
    reset_n = 1'b0;
    repeat (4) @(negedge clk);
    chk("reset_miso", {31'd0, spi_miso}, 32'd0);
    chk("reset_rom_addr", {21'd0, rom_addr}, 32'd0);
    chk("reset_active", {31'd0, active}, 32'd0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // READ 000010h, 4 bytes at f_clk/16
    xfer(8'h03, 24'h000010, 64, 8, -1);
    chk("rd10_b0", {24'd0, rx_byte(32)}, 32'hB5);
    chk("rd10_b1", {24'd0, rx_byte(40)}, 32'hB4);
    chk("rd10_b2", {24'd0, rx_byte(48)}, 32'hB7);
    chk("rd10_b3", {24'd0, rx_byte(56)}, 32'hB6);

    // Address wrap, then the same read with the ignored upper address bits set
    xfer(8'h03, 24'h0007FE, 64, 8, -1);
    chk("wrap_b0", {24'd0, rx_byte(32)}, 32'h5B);
    chk("wrap_b1", {24'd0, rx_byte(40)}, 32'h5A);
    chk("wrap_b2", {24'd0, rx_byte(48)}, 32'hA5);
    chk("wrap_b3", {24'd0, rx_byte(56)}, 32'hA4);
    xfer(8'h03, 24'hFFFFFE, 64, 7, -1);
    chk("wrap_hi_b0", {24'd0, rx_byte(32)}, 32'h5B);
    chk("wrap_hi_b3", {24'd0, rx_byte(56)}, 32'hA4);

    // Unsupported command followed by 40 clocks
    xfer(8'h9F, 24'h000000, 48, 8, -1);

    // Transfer aborted after 20 address bits, then a fresh read
    xfer(8'h03, 24'h123456, 28, 8, -1);
    xfer(8'h03, 24'h000003, 40, 8, -1);
    chk("after_abort_b0", {24'd0, rx_byte(32)}, 32'hA6);

    // FAST_READ with 8 dummy clocks
    xfer(8'h0B, 24'h000005, 56, 8, -1);
    chk("fast_dummy_byte", {24'd0, rx_byte(32)}, 32'h00);
    chk("fast_b0", {24'd0, rx_byte(40)}, FAST ? 32'hA0 : 32'h00);

    // Reset in the middle of DATA, then a clean read
    xfer(8'h03, 24'h000020, 64, 8, 45);
    xfer(8'h03, 24'h000021, 48, 8, -1);
    chk("after_reset_b0", {24'd0, rx_byte(32)}, 32'h84);

    // Randomized transfers checked by the scoreboard
    for (int t = 0; t < 10; t++) begin
      case ($urandom_range(0, 3))
        0:       cmd = 8'h03;
        1:       cmd = 8'h0B;
        2:       cmd = 8'h9F;
        default: cmd = 8'($urandom_range(0, 255));
      endcase
      addr   = 24'($urandom);
      nbytes = $urandom_range(1, 4);
      xfer(cmd, addr, 40 + 8 * nbytes, $urandom_range(6, 10), -1);
    end

    chk("exp_q_drained", {31'd0, exp_q.size() == 0}, 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
